// File: rtl/mem_access_stage.sv
// MEM stage: branch resolve, req/ack data-memory access, MEM/WB register; WB_* one edge after release.
// Backpressure: Stall held combinationally from access issue until the cycle Dmem_ack arrives.
module mem_access_stage (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [31:0] Branch_addr,
    input  logic [31:0] PC_add,
    input  logic [2:0]  Condition,
    input  logic        Branch,
    input  logic [3:0]  Mem_Byte_Write,
    input  logic [3:0]  Rd_Write_Byte_en,
    input  logic        MemWBSrc,
    input  logic        OverflowEn,
    input  logic        Overflow,
    input  logic [31:0] MemData,
    input  logic [31:0] WBData,
    input  logic        Less,
    input  logic        Zero,
    input  logic [4:0]  Rd,
    output logic        Dmem_req,
    output logic [3:0]  Dmem_we,
    output logic [31:0] Dmem_addr,
    output logic [31:0] Dmem_wdata,
    input  logic [31:0] Dmem_rdata,
    input  logic        Dmem_ack,
    output logic        Stall,
    output logic        Branch_taken,
    output logic [31:0] Branch_target,
    output logic [31:0] WB_Data,
    output logic [4:0]  WB_Rd,
    output logic [3:0]  WB_Byte_en,
    output logic        Ovf_Exc,
    output logic [31:0] Exc_PC
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [3:0]  byte_en;
    } memwb_t;

    state_t state;
    memwb_t wb_q;
    memwb_t wb_d;

    logic is_store;
    logic access;
    logic ovf;
    logic cond_true;

    assign is_store = |Mem_Byte_Write;
    assign access   = is_store | MemWBSrc;
    assign ovf      = OverflowEn & Overflow;

    assign Stall = ((state == ST_IDLE) & access & ~ovf) |
                   ((state == ST_BUSY) & ~Dmem_ack);

    always_comb begin
        cond_true = 1'b0;
        case (Condition)
            3'b000:  cond_true = 1'b0;
            3'b001:  cond_true = Zero;
            3'b010:  cond_true = ~Zero;
            3'b011:  cond_true = Less;
            3'b100:  cond_true = ~Less;
            3'b101:  cond_true = ~Less & ~Zero;
            3'b110:  cond_true = Less | Zero;
            default: cond_true = 1'b1;
        endcase
    end

    // A stalled instruction must not redirect until it is actually leaving MEM.
    assign Branch_taken  = Branch & cond_true & ~Stall;
    assign Branch_target = Branch_addr;

    // Bubble while stalled so the held instruction writes back exactly once.
    always_comb begin
        wb_d = '0;
        if (!Stall) begin
            wb_d.data    = MemWBSrc ? Dmem_rdata : WBData;
            wb_d.rd      = Rd;
            wb_d.byte_en = (ovf | is_store) ? 4'h0 : Rd_Write_Byte_en;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state      <= ST_IDLE;
            Dmem_req   <= 1'b0;
            Dmem_we    <= 4'h0;
            Dmem_addr  <= 32'h0;
            Dmem_wdata <= 32'h0;
            wb_q       <= '0;
            Ovf_Exc    <= 1'b0;
            Exc_PC     <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (access && !ovf) begin
                        Dmem_req   <= 1'b1;
                        Dmem_we    <= Mem_Byte_Write;
                        Dmem_addr  <= {WBData[31:2], 2'b00};
                        Dmem_wdata <= MemData;
                        state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (Dmem_ack) begin
                        Dmem_req <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            wb_q    <= wb_d;
            Ovf_Exc <= ovf & ~Stall;
            if (ovf && !Stall) begin
                Exc_PC <= PC_add;
            end
        end
    end

    assign WB_Data    = wb_q.data;
    assign WB_Rd      = wb_q.rd;
    assign WB_Byte_en = wb_q.byte_en;

endmodule
